adder_share_sequencer: RTL

Time-shares one external combinational 8-bit parallel adder (A, B, Cin -> Sum, Cout) between two requesters. Each requester submits a multi-byte add. The block grants requesters round-robin, feeds the operands through the adder one byte per cycle LSB-first with the carry chained through a register, then returns the assembled wide sum and carry-out. It sits between the requesting logic and the shared adder instance at tile top level.

---
 rtl/adder_share_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/adder_share_sequencer.sv
// Round-robin sequencer that time-shares one external 8-bit adder between two
// requesters, streaming multi-byte operands LSB-first with a registered carry.
module adder_share_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [8*NBYTES-1:0]   r0_a,
  input  logic [8*NBYTES-1:0]   r0_b,
  input  logic                  r0_cin,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [8*NBYTES-1:0]   r1_a,
  input  logic [8*NBYTES-1:0]   r1_b,
  input  logic                  r1_cin,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_id,
  output logic [8*NBYTES-1:0]   res_sum,
  output logic                  res_cout,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout
);
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q;
  logic                   carry_q;
  logic                   last_grant_q;
  logic                   owner_q;
  logic [NBYTES-1:0][7:0] a_q, b_q, work_q, sum_full;
  logic [8*NBYTES-1:0]    res_sum_q;
  logic                   res_id_q, res_cout_q;
  logic                   any_v, sel, accept, last_byte;

  always_comb begin
    any_v     = r0_valid | r1_valid;
    // On a tie the requester that did not win last time is chosen.
    sel       = (r0_valid & r1_valid) ? ~last_grant_q : r1_valid;
    r0_ready  = (state_q == IDLE) & ena & any_v & ~sel;
    r1_ready  = (state_q == IDLE) & ena & any_v & sel;
    accept    = r0_ready | r1_ready;
    last_byte = (cnt_q == LAST);

    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (ena && last_byte) state_d = DONE;
      DONE:    if (ena && res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a   = a_q[cnt_q];
      add_b   = b_q[cnt_q];
      add_cin = carry_q;
    end

    // Working sum with the byte being added this cycle merged in, so the
    // published result is updated only once, at completion.
    sum_full        = work_q;
    sum_full[cnt_q] = add_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      carry_q      <= 1'b0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      work_q       <= '0;
      res_sum_q    <= '0;
      res_id_q     <= 1'b0;
      res_cout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q          <= r1_ready ? r1_a : r0_a;
        b_q          <= r1_ready ? r1_b : r0_b;
        carry_q      <= r1_ready ? r1_cin : r0_cin;
        owner_q      <= r1_ready;
        last_grant_q <= r1_ready;
        cnt_q        <= '0;
      end else if (state_q == RUN && ena) begin
        work_q[cnt_q] <= add_sum;
        carry_q       <= add_cout;
        cnt_q         <= cnt_q + CW'(1);
        if (last_byte) begin
          res_sum_q  <= sum_full;
          res_cout_q <= add_cout;
          res_id_q   <= owner_q;
          cnt_q      <= '0;
        end
      end
    end
  end

  assign res_valid = (state_q == DONE);
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;

endmodule
